// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: control bundle layout and field encodings.
// Latency: none (package only; types, constants and one pure helper function).
// Backpressure: none (no logic of its own).
// Shared by the decoder, the ID/EX register and the hazard logic.
package pipeline_pkg;

  // Control bundle, MSB first:
  // {RegWrite, MemRead, MemWrite, MemtoReg[1:0], RegDst[1:0], ALUSrcA, ALUSrcB, ALUOp[2:0], Branch[2:0]}
  localparam int CTRL_W          = 15;
  localparam int CTRL_REG_WRITE  = 14;
  localparam int CTRL_MEM_READ   = 13;
  localparam int CTRL_MEM_WRITE  = 12;
  localparam int CTRL_MEMTOREG_L = 10;
  localparam int CTRL_REGDST_L   = 8;
  localparam int CTRL_ALUSRC_A   = 7;
  localparam int CTRL_ALUSRC_B   = 6;
  localparam int CTRL_ALUOP_L    = 3;
  localparam int CTRL_BRANCH_L   = 0;

  // Destination register select
  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_RA   = 2'b10,
    REGDST_NONE = 2'b11
  } regDst_e;

  // Write-back source select
  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10,
    MTR_IMM = 2'b11
  } memtoReg_e;

  // ALU operation class handed to the ALU control
  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_FUNCT = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_LUI   = 3'b110,
    ALUOP_XOR   = 3'b111
  } aluOp_e;

  // Branch / jump kind resolved in EX
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_J    = 3'b101,
    BR_JAL  = 3'b110,
    BR_JR   = 3'b111
  } branch_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Architectural destination of an instruction from its RegDst select.
  // REGDST_NONE maps to $0, which is never a hazard source.
  function automatic logic [4:0] selectDst(input logic [1:0] regDst,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
    logic [4:0] dst;
    case (regDst)
      REGDST_RT: dst = rt;
      REGDST_RD: dst = rd;
      REGDST_RA: dst = REG_RA;
      default:   dst = REG_ZERO;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use and jr/jalr read-after-write hazard detection for the ID stage.
// Latency: purely combinational, stall valid in the same cycle as its inputs.
// Backpressure: stall holds PC and IF/ID; a taken branch in EX overrides it to 0.
// Ports: rstN (async reset, forces stall low), EX-slot control/register fields,
//        ID source fields, taken-branch flag, MEM load flag/destination; output stall.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       rstN,
  input  logic       exRegWrite,
  input  logic       exMemRead,
  input  logic [1:0] exRegDst,
  input  logic       exValid,
  input  logic [4:0] exRt,
  input  logic [4:0] exRd,
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       idIsJr,
  input  logic       branchTaken,
  input  logic       memMemRead,
  input  logic [4:0] memDst,
  output logic       stall
);

  logic [4:0] exDst;
  logic       loadUse;
  logic       jrFromEx;
  logic       jrFromMem;
  logic       jrHazard;

  always_comb begin
    exDst = selectDst(exRegDst, exRt, exRd);

    // lw in EX feeding either source of the ID instruction; data only
    // becomes forwardable after MEM, so one bubble is required.
    loadUse = exMemRead && exValid && (exRt != REG_ZERO) &&
              ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

    // jr/jalr read their target in ID, ahead of the normal forwarding
    // point: any writer in EX, or a load still in MEM, must drain first.
    jrFromEx  = exRegWrite && exValid && (exDst == idRs);
    jrFromMem = memMemRead && (memDst == idRs);
    jrHazard  = idIsJr && (idRs != REG_ZERO) && (jrFromEx || jrFromMem);

    // A taken branch makes the ID instruction wrong-path, so it never stalls.
    stall = rstN && idValid && !branchTaken && (loadUse || jrHazard);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, branch flush and saturating event counters.
// Latency: 1 cycle from ID inputs to EX outputs; stall is combinational.
// Backpressure: stall=1 freezes PC and IF/ID and injects a NOP into EX; flush beats stall.
// Ports: clk/rst_n; id_* decoder bundle and datapath fields; ex_branch_taken; mem_mem_read/mem_dst;
//        ex_* registered outputs; stall; stall_count/flush_count.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = CTRL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] id_ctrl,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_funct,
  input  logic          id_uses_rt,
  input  logic          id_is_jr,
  input  logic          ex_branch_taken,
  input  logic          mem_mem_read,
  input  logic [4:0]    mem_dst,
  output logic [CW-1:0] ex_ctrl,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [4:0]    ex_shamt,
  output logic [5:0]    ex_funct,
  output logic          stall,
  output logic [DW-1:0] stall_count,
  output logic [DW-1:0] flush_count
);

  localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};

  logic killSlot;

  hazard_detect uHazard (
    .rstN        (rst_n),
    .exRegWrite  (ex_ctrl[CTRL_REG_WRITE]),
    .exMemRead   (ex_ctrl[CTRL_MEM_READ]),
    .exRegDst    (ex_ctrl[CTRL_REGDST_L +: 2]),
    .exValid     (ex_valid),
    .exRt        (ex_rt),
    .exRd        (ex_rd),
    .idValid     (id_valid),
    .idRs        (id_rs),
    .idRt        (id_rt),
    .idUsesRt    (id_uses_rt),
    .idIsJr      (id_is_jr),
    .branchTaken (ex_branch_taken),
    .memMemRead  (mem_mem_read),
    .memDst      (mem_dst),
    .stall       (stall)
  );

  // Flush and bubble both turn the EX slot into a NOP; stall is already
  // forced low by a taken branch, so the OR keeps flush as top priority.
  assign killSlot = ex_branch_taken || stall;

  // Control and valid: the only fields that distinguish a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
    end else if (killSlot) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
    end else begin
      ex_ctrl  <= id_ctrl;
      ex_valid <= id_valid;
    end
  end

  // Datapath fields load unconditionally; a killed slot carries harmless
  // data because its control is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_funct   <= '0;
    end else begin
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
      ex_funct   <= id_funct;
    end
  end

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (ex_branch_taken && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: behavioural model with per-cycle compare plus directed literal checks.
// Latency: model mirrors the 1-cycle register; stall is checked combinationally.
// Backpressure: stalls are provoked through load-use and jr hazards and overridden by flushes.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 15;
  localparam int SW = 4;   // narrow build to reach counter saturation quickly

  localparam logic [CW-1:0] LW_CTRL  = 15'h6440; // RegWrite, MemRead, MemtoReg=01, RegDst=rt, ALUSrcB
  localparam logic [CW-1:0] ADD_CTRL = 15'h4110; // RegWrite, RegDst=rd, ALUOp=funct
  localparam logic [CW-1:0] JR_CTRL  = 15'h0007; // Branch=jr, no write

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] id_ctrl;
  logic          id_valid;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]    id_funct;
  logic          id_uses_rt, id_is_jr, ex_branch_taken, mem_mem_read;
  logic [4:0]    mem_dst;

  logic [CW-1:0] ex_ctrl;
  logic          ex_valid;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]    ex_funct;
  logic          stall;
  logic [DW-1:0] stall_count, flush_count;

  logic [CW-1:0] sCtrl;
  logic          sValid, sStall;
  logic [SW-1:0] sPc4, sRsData, sRtData, sImm, sStallCnt, sFlushCnt;
  logic [4:0]    sRs, sRt, sRd, sShamt;
  logic [5:0]    sFunct;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_uses_rt(id_uses_rt), .id_is_jr(id_is_jr), .ex_branch_taken(ex_branch_taken),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct), .stall(stall),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  id_ex_stage #(.DW(SW), .CW(CW)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_pc4(id_pc4[SW-1:0]), .id_rs_data(id_rs_data[SW-1:0]), .id_rt_data(id_rt_data[SW-1:0]),
    .id_imm(id_imm[SW-1:0]), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_uses_rt(id_uses_rt), .id_is_jr(id_is_jr),
    .ex_branch_taken(ex_branch_taken), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .ex_ctrl(sCtrl), .ex_valid(sValid), .ex_pc4(sPc4), .ex_rs_data(sRsData),
    .ex_rt_data(sRtData), .ex_imm(sImm), .ex_rs(sRs), .ex_rt(sRt), .ex_rd(sRd),
    .ex_shamt(sShamt), .ex_funct(sFunct), .stall(sStall),
    .stall_count(sStallCnt), .flush_count(sFlushCnt)
  );

  // ---------------- behavioural model ----------------
  // Model EX slot: what instruction sits in EX and how many events have happened.
  logic [CW-1:0] mCtrl = '0;
  logic          mValid = 1'b0;
  logic [DW-1:0] mPc4 = '0, mRsD = '0, mRtD = '0, mImm = '0;
  logic [4:0]    mRs = '0, mRt = '0, mRd = '0, mSh = '0;
  logic [5:0]    mFn = '0;
  longint        mStalls = 0, mFlushes = 0;
  logic          mS;

  function automatic logic [4:0] modelDst();
    logic [1:0] sel;
    sel = mCtrl[9:8];
    if (sel == 2'b00) return mRt;
    if (sel == 2'b01) return mRd;
    if (sel == 2'b10) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic modelStall();
    logic lu, jr;
    lu = mCtrl[13] && mValid && (mRt != 0) &&
         ((mRt == id_rs) || (id_uses_rt && (mRt == id_rt)));
    jr = id_is_jr && (id_rs != 0) &&
         ((mCtrl[14] && mValid && (modelDst() == id_rs)) ||
          (mem_mem_read && (mem_dst == id_rs)));
    return rst_n && id_valid && !ex_branch_taken && (lu || jr);
  endfunction

  function automatic logic [DW-1:0] satCount(input longint n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (n > lim) ? lim[DW-1:0] : n[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCtrl = '0; mValid = 1'b0;
      mPc4 = '0; mRsD = '0; mRtD = '0; mImm = '0;
      mRs = '0; mRt = '0; mRd = '0; mSh = '0; mFn = '0;
      mStalls = 0; mFlushes = 0;
    end else begin
      mS = modelStall();
      if (mS) mStalls++;
      if (ex_branch_taken) mFlushes++;
      if (ex_branch_taken || mS) begin
        mCtrl = '0; mValid = 1'b0;
      end else begin
        mCtrl = id_ctrl; mValid = id_valid;
      end
      mPc4 = id_pc4; mRsD = id_rs_data; mRtD = id_rt_data; mImm = id_imm;
      mRs = id_rs; mRt = id_rt; mRd = id_rd; mSh = id_shamt; mFn = id_funct;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    chk("ex_ctrl",     64'(ex_ctrl),     64'(mCtrl));
    chk("ex_valid",    64'(ex_valid),    64'(mValid));
    chk("ex_pc4",      64'(ex_pc4),      64'(mPc4));
    chk("ex_rs_data",  64'(ex_rs_data),  64'(mRsD));
    chk("ex_rt_data",  64'(ex_rt_data),  64'(mRtD));
    chk("ex_imm",      64'(ex_imm),      64'(mImm));
    chk("ex_rs",       64'(ex_rs),       64'(mRs));
    chk("ex_rt",       64'(ex_rt),       64'(mRt));
    chk("ex_rd",       64'(ex_rd),       64'(mRd));
    chk("ex_shamt",    64'(ex_shamt),    64'(mSh));
    chk("ex_funct",    64'(ex_funct),    64'(mFn));
    chk("stall",       64'(stall),       64'(modelStall()));
    chk("stall_count", 64'(stall_count), 64'(satCount(mStalls, DW)));
    chk("flush_count", 64'(flush_count), 64'(satCount(mFlushes, DW)));
    chk("narrow_stall_count", 64'(sStallCnt), 64'(satCount(mStalls, SW)));
    chk("narrow_flush_count", 64'(sFlushCnt), 64'(satCount(mFlushes, SW)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randData();
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_shamt = 5'($urandom); id_funct = 6'($urandom);
  endtask

  task automatic setId(input logic [CW-1:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic usesRt, input logic isJr);
    id_ctrl = ctrl; id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rt = usesRt; id_is_jr = isJr;
    randData();
  endtask

  task automatic clearSide();
    ex_branch_taken = 1'b0; mem_mem_read = 1'b0; mem_dst = 5'd0;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clearSide();
    setId('0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    #1 rst_n = 1'b0;

    // Reset with random inputs: everything held at zero, stall low.
    repeat (3) begin
      id_ctrl = CW'($urandom); id_valid = 1'b1; id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_rd = 5'($urandom); id_uses_rt = 1'b1; id_is_jr = 1'b1;
      ex_branch_taken = 1'($urandom); mem_mem_read = 1'b1; mem_dst = id_rs;
      randData();
      tick();
      chk("reset_ex_ctrl", 64'(ex_ctrl), 64'h0);
      chk("reset_ex_valid", 64'(ex_valid), 64'h0);
      chk("reset_stall", 64'(stall), 64'h0);
      chk("reset_stall_count", 64'(stall_count), 64'h0);
    end
    clearSide();
    rst_n = 1'b1;
    setId(15'h4401, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick();
    chk("first_ctrl", 64'(ex_ctrl), 64'h4401);
    chk("first_valid", 64'(ex_valid), 64'h1);

    // Load-use: lw $8 then add using $8 -> one bubble.
    setId(LW_CTRL, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    setId(ADD_CTRL, 5'd8, 5'd2, 5'd3, 1'b1, 1'b0);
    #1 chk("lu_stall", 64'(stall), 64'h1);
    tick();
    chk("lu_bubble_ctrl", 64'(ex_ctrl), 64'h0);
    chk("lu_bubble_valid", 64'(ex_valid), 64'h0);
    chk("lu_stall_count", 64'(stall_count), 64'd1);
    chk("lu_released", 64'(stall), 64'h0);
    tick();
    chk("lu_add_in_ex", 64'(ex_ctrl), 64'(ADD_CTRL));

    // lw to $0 never stalls.
    setId(LW_CTRL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    setId(ADD_CTRL, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    #1 chk("zero_no_stall", 64'(stall), 64'h0);
    tick();

    // rt match only matters when the ID instruction reads rt.
    setId(LW_CTRL, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    tick();
    setId(ADD_CTRL, 5'd4, 5'd9, 5'd0, 1'b0, 1'b0);
    #1 chk("rt_unused_no_stall", 64'(stall), 64'h0);
    id_uses_rt = 1'b1;
    #1 chk("rt_used_stall", 64'(stall), 64'h1);
    tick();
    chk("rt_count", 64'(stall_count), 64'd2);

    // lw $31 then jr $31 -> two stall cycles.
    pulseReset();
    setId(LW_CTRL, 5'd2, 5'd31, 5'd0, 1'b0, 1'b0);
    tick();
    setId(JR_CTRL, 5'd31, 5'd0, 5'd0, 1'b0, 1'b1);
    #1 chk("jr_stall1", 64'(stall), 64'h1);
    tick();
    mem_mem_read = 1'b1; mem_dst = 5'd31;
    #1 chk("jr_stall2", 64'(stall), 64'h1);
    tick();
    clearSide();
    #1 chk("jr_go", 64'(stall), 64'h0);
    chk("jr_count", 64'(stall_count), 64'd2);
    tick();
    chk("jr_in_ex", 64'(ex_ctrl), 64'(JR_CTRL));

    // ALU result feeding jr -> one stall.
    setId(ADD_CTRL, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    setId(JR_CTRL, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
    #1 chk("alu_jr_stall", 64'(stall), 64'h1);
    tick();
    #1 chk("alu_jr_go", 64'(stall), 64'h0);
    chk("alu_jr_count", 64'(stall_count), 64'd3);
    tick();

    // Flush wins over a load-use stall.
    setId(LW_CTRL, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    tick();
    setId(ADD_CTRL, 5'd8, 5'd2, 5'd3, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1 chk("flush_stall_low", 64'(stall), 64'h0);
    tick();
    clearSide();
    chk("flush_ctrl", 64'(ex_ctrl), 64'h0);
    chk("flush_valid", 64'(ex_valid), 64'h0);
    chk("flush_count", 64'(flush_count), 64'd1);
    chk("flush_no_stall_count", 64'(stall_count), 64'd3);

    // Saturation: persistent jr-vs-load-in-MEM stall, then persistent flush.
    setId(JR_CTRL, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
    mem_mem_read = 1'b1; mem_dst = 5'd5;
    repeat (20) tick();
    chk("sat_narrow_stall", 64'(sStallCnt), 64'hF);
    chk("sat_wide_stall", 64'(stall_count), 64'd23);
    clearSide();
    ex_branch_taken = 1'b1;
    repeat (20) tick();
    chk("sat_narrow_flush", 64'(sFlushCnt), 64'hF);
    chk("sat_wide_flush", 64'(flush_count), 64'd21);
    clearSide();

    // Asynchronous reset in the middle of a jr double stall.
    pulseReset();
    setId(LW_CTRL, 5'd2, 5'd31, 5'd0, 1'b0, 1'b0);
    tick();
    setId(JR_CTRL, 5'd31, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    mem_mem_read = 1'b1; mem_dst = 5'd31;
    #1 chk("mid_stall", 64'(stall), 64'h1);
    chk("mid_stall_count", 64'(stall_count), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ctrl", 64'(ex_ctrl), 64'h0);
    chk("async_pc4", 64'(ex_pc4), 64'h0);
    chk("async_stall", 64'(stall), 64'h0);
    chk("async_stall_count", 64'(stall_count), 64'h0);
    chk("async_flush_count", 64'(flush_count), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clearSide();
    setId(ADD_CTRL, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0);
    tick();
    chk("post_reset_ctrl", 64'(ex_ctrl), 64'(ADD_CTRL));
    chk("post_reset_valid", 64'(ex_valid), 64'h1);
    tick();
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the instruction decoder.
- Latches the decoder's control bundle and the ID datapath fields for the EX stage.
- Detects load-use and jr/jalr read-after-write hazards, stalls IF/ID and inserts bubbles.
- Flushes on a taken branch resolved in EX, and keeps saturating stall and flush event counters.

Parameters:
- DW, 32, datapath width (PC+4, register data, extended immediate, counters).
- CW, 15, control bundle width; layout MSB first: {RegWrite, MemRead, MemWrite, MemtoReg[1:0], RegDst[1:0], ALUSrcA, ALUSrcB, ALUOp[2:0], Branch[2:0]}.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_ctrl  in  CW  control bundle from the decoder
- id_valid  in  1  ID holds a real instruction
- id_pc4, id_rs_data, id_rt_data, id_imm  in  DW each  PC+4, register reads, extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_funct  in  6  funct field
- id_uses_rt  in  1  instruction reads rt as a source (R-type, beq, bne, sw)
- id_is_jr  in  1  jr or jalr in ID (target register read in ID)
- ex_branch_taken  in  1  branch taken, resolved in EX this cycle
- mem_mem_read  in  1  instruction in MEM is lw
- mem_dst  in  5  destination register of the instruction in MEM
- ex_ctrl  out  CW  registered control bundle
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DW each
- ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each
- ex_funct  out  6
- stall  out  1  combinational; holds PC and IF/ID
- stall_count, flush_count  out  DW each  saturating event counters

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, including both counters. A zero ex_ctrl is a NOP: no RegWrite, no MemRead, no MemWrite, Branch=000. stall is 0 while in reset.
- Latency: 1 cycle from ID inputs to EX outputs. On each rising edge exactly one of the following applies, highest priority first:
  1. Flush (ex_branch_taken=1): ex_ctrl<=0, ex_valid<=0.
  2. Bubble (stall=1): ex_ctrl<=0, ex_valid<=0.
  3. Normal: ex_ctrl<=id_ctrl, ex_valid<=id_valid.
- Data fields (pc4, rs/rt data, imm, rs, rt, rd, shamt, funct) load from ID on every edge, in all three cases above.
- EX destination ex_dst (combinational), decoded from ex_ctrl.RegDst: 00 gives ex_rt, 01 gives ex_rd, 10 gives 31, 11 gives 0.
- Load-use hazard: ex_ctrl.MemRead && ex_valid && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- jr/jalr hazard: id_is_jr && id_rs!=0 && one of:
  - ex_ctrl.RegWrite && ex_valid && ex_dst==id_rs;
  - mem_mem_read && mem_dst==id_rs.
- stall = id_valid && !ex_branch_taken && (load-use hazard || jr/jalr hazard). A taken branch forces stall to 0, because the ID instruction is wrong-path.
- Stall duration:
  - lw then a dependent instruction: exactly 1 stall cycle.
  - ALU op then a dependent jr: 1 stall cycle.
  - lw then a dependent jr: 2 stall cycles, once with the lw in EX and once with it in MEM.
- Register $0 never causes a hazard.
- stall_count increments by 1 on each edge where stall=1. flush_count increments on each edge where ex_branch_taken=1. Both saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-flush clears all state immediately. The first edge after rst_n rises behaves as normal.

Decomposition:
- Shared package pipeline_pkg holds:
  - the CW control-bundle field offsets;
  - RegDst, MemtoReg, ALUOp and Branch encodings;
  - opcode and funct constants, shared with the decoder.
- Sub-module hazard_detect (purely combinational) computes ex_dst and stall.
- id_ex_stage holds the registers and counters.

Test Plan:
- Reset: drive random inputs with rst_n=0 -> all outputs 0, stall=0. Release rst_n, apply id_ctrl=15'h4401 -> ex_ctrl=15'h4401 one cycle later.
- Load-use: lw $8 in EX (MemRead=1, ex_rt=8), ID add with id_rs=8 -> stall=1 for 1 cycle, next ex_ctrl=0, ex_valid=0, stall_count=1. Repeat with ex_rt=0 -> stall=0.
- jr after lw: lw $31 followed by jr $31 -> stall=1 for 2 consecutive cycles (lw in EX, then mem_mem_read=1, mem_dst=31). stall_count=2; jr enters EX on cycle 3.
- Flush over stall: load-use condition plus ex_branch_taken=1 -> stall=0, ex_ctrl=0, ex_valid=0, flush_count=1.
- Saturation: force 2^32+5 stall cycles (or a reduced-DW build) -> stall_count holds at all-ones.
- Reset mid-stall: assert rst_n=0 asynchronously during a jr double stall -> outputs 0 immediately, without waiting for a clock edge, and counters cleared.
